id_ex_stage: RTL and testbench

//  ID/EX pipeline boundary of the 5-stage RV32I core, directly downstream of the control unit.

---
 rtl/rv32i_pkg.sv | 36 +++
 rtl/id_ex_stage_if.sv | 32 +++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 116 +++++++++++
 tb/tb_id_ex_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcodes, result-source encoding and the decoded control bundle.
// Also holds the operand-use helpers used by hazard detection.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  // An all-zero bundle is a NOP: nothing written, nothing stored, no control transfer.
  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic       branch;
    logic       jump;
  } ctrl_bundle_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side decoded instruction and EX-side registered copy crossing the ID/EX boundary.
interface id_ex_stage_if #(parameter int XLEN = 32);
  logic [6:0]      OpD;
  logic            RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD;
  logic [1:0]      ResultSrcD;
  logic [3:0]      ALUControlD;
  logic [2:0]      Funct3D;
  logic [XLEN-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]      Rs1D, Rs2D, RdD;

  logic            RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;
  logic [2:0]      Funct3E;
  logic [XLEN-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic            ValidE;

  modport master (
    output OpD, RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD, ResultSrcD, ALUControlD,
           Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    input  RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE,
           Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE
  );

  modport slave (
    input  OpD, RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD, ResultSrcD, ALUControlD,
           Funct3D, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
    output RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE, ResultSrcE, ALUControlE,
           Funct3E, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, ValidE
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection: a valid load in EX whose destination
// is a source register actually read by the instruction in ID.
module load_use_detect
  import rv32i_pkg::*;
(
  input  logic [6:0] op_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic [4:0] rd_e,
  input  logic [1:0] result_src_e,
  input  logic       valid_e,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = uses_rs1(op_d) && (rs1_d == rd_e);
    rs2_hit  = uses_rs2(op_d) && (rs2_d == rd_e);
    // x0 is never a real dependency even if a load names it as destination.
    load_use = (result_src_e == RESULT_MEM) && valid_e && (rd_e != 5'd0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, bubble insertion on
// hazard or flush, and a saturating bubble counter.
module id_ex_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  id_ex_stage_if.slave     bus,
  input  logic             FlushE,
  output logic             StallF,
  output logic             StallD,
  output logic [CNT_W-1:0] BubbleCnt
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
  } data_t;

  ctrl_bundle_t     ctrl_d, ctrl_q;
  data_t            data_d, data_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
  logic             load_use;
  logic             bubble;

  load_use_detect u_load_use_detect (
    .op_d         (bus.OpD),
    .rs1_d        (bus.Rs1D),
    .rs2_d        (bus.Rs2D),
    .rd_e         (data_q.rd),
    .result_src_e (ctrl_q.result_src),
    .valid_e      (valid_q),
    .load_use     (load_use)
  );

  // NOTE: every always_comb output gets a value on every path first, so no latch is inferred.
  always_comb begin
    bubble = FlushE | load_use;
    // A flush kills the ID instruction anyway, so stalling it would only delay the redirect.
    StallF = load_use & ~FlushE;
    StallD = load_use & ~FlushE;

    // Data fields are don't-care in a bubble; capturing unconditionally keeps the mux off them.
    data_d.rd1      = bus.RD1D;
    data_d.rd2      = bus.RD2D;
    data_d.pc       = bus.PCD;
    data_d.pc_plus4 = bus.PCPlus4D;
    data_d.imm_ext  = bus.ImmExtD;
    data_d.rs1      = bus.Rs1D;
    data_d.rs2      = bus.Rs2D;
    data_d.rd       = bus.RdD;
    data_d.funct3   = bus.Funct3D;

    ctrl_d = '0;
    if (!bubble) begin
      ctrl_d.reg_write   = bus.RegWriteD;
      ctrl_d.alu_src     = bus.ALUSrcD;
      ctrl_d.mem_write   = bus.MemWriteD;
      ctrl_d.result_src  = bus.ResultSrcD;
      ctrl_d.alu_control = bus.ALUControlD;
      ctrl_d.branch      = bus.BranchD;
      ctrl_d.jump        = bus.JumpD;
    end
    valid_d = ~bubble;

    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != {CNT_W{1'b1}}))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q       <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.ResultSrcE  = ctrl_q.result_src;
  assign bus.ALUControlE = ctrl_q.alu_control;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.JumpE       = ctrl_q.jump;
  assign bus.RD1E        = data_q.rd1;
  assign bus.RD2E        = data_q.rd2;
  assign bus.PCE         = data_q.pc;
  assign bus.PCPlus4E    = data_q.pc_plus4;
  assign bus.ImmExtE     = data_q.imm_ext;
  assign bus.Rs1E        = data_q.rs1;
  assign bus.Rs2E        = data_q.rs2;
  assign bus.RdE         = data_q.rd;
  assign bus.Funct3E     = data_q.funct3;
  assign bus.ValidE      = valid_q;
  assign BubbleCnt       = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, load-use stall, operand qualification,
// flush priority, counter saturation (4-bit build) and asynchronous reset.
module tb_id_ex_stage;
  import rv32i_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush_e, flush4;
  logic        stall_f, stall_d, stall_f4, stall_d4;
  logic [31:0] bubble_cnt;
  logic [3:0]  cnt4;

  int passed;
  int total;
  int exp_cnt;

  id_ex_stage_if #(.XLEN(32)) bus ();
  id_ex_stage_if #(.XLEN(32)) bus4 ();

  id_ex_stage #(.XLEN(32), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .FlushE(flush_e),
    .StallF(stall_f), .StallD(stall_d), .BubbleCnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .FlushE(flush4),
    .StallF(stall_f4), .StallD(stall_d4), .BubbleCnt(cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [1:0] rsrc, input logic regw,
                           input logic alusrc, input logic memw, input logic [3:0] aluc,
                           input logic [31:0] rd1, input logic [31:0] rd2);
    bus.OpD = op; bus.Rs1D = rs1; bus.Rs2D = rs2; bus.RdD = rd;
    bus.ResultSrcD = rsrc; bus.RegWriteD = regw; bus.ALUSrcD = alusrc;
    bus.MemWriteD = memw; bus.ALUControlD = aluc; bus.RD1D = rd1; bus.RD2D = rd2;
    bus.BranchD = 1'b0; bus.JumpD = 1'b0;
    #1;
  endtask

  task automatic clear_inputs();
    bus.OpD = '0; bus.RegWriteD = 0; bus.ALUSrcD = 0; bus.MemWriteD = 0; bus.BranchD = 0;
    bus.JumpD = 0; bus.ResultSrcD = '0; bus.ALUControlD = '0; bus.Funct3D = '0;
    bus.RD1D = '0; bus.RD2D = '0; bus.PCD = '0; bus.PCPlus4D = '0; bus.ImmExtD = '0;
    bus.Rs1D = '0; bus.Rs2D = '0; bus.RdD = '0;
    bus4.OpD = '0; bus4.RegWriteD = 0; bus4.ALUSrcD = 0; bus4.MemWriteD = 0; bus4.BranchD = 0;
    bus4.JumpD = 0; bus4.ResultSrcD = '0; bus4.ALUControlD = '0; bus4.Funct3D = '0;
    bus4.RD1D = '0; bus4.RD2D = '0; bus4.PCD = '0; bus4.PCPlus4D = '0; bus4.ImmExtD = '0;
    bus4.Rs1D = '0; bus4.Rs2D = '0; bus4.RdD = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_e = 1'b0; flush4 = 1'b0;
    clear_inputs();
    #2;
    total++; if (bus.ValidE !== 1'b0) $display("FAIL reset_valid: got %0h expected 0", bus.ValidE); else passed++;
    total++; if (bubble_cnt !== 32'd0) $display("FAIL reset_cnt: got %0h expected 0", bubble_cnt); else passed++;
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) $display("FAIL reset_stall: got %b%b expected 00", stall_f, stall_d); else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_add();
    bus.PCD = 32'h40; bus.PCPlus4D = 32'h44; bus.ImmExtD = 32'h7; bus.Funct3D = 3'b101;
    set_instr(OP_R, 5'd1, 5'd2, 5'd3, RESULT_ALU, 1'b1, 1'b0, 1'b0, 4'h0, 32'h11, 32'h22);
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) $display("FAIL add_stall_d: got %b%b expected 00", stall_f, stall_d); else passed++;
    step();
    total++; if (bus.RD1E !== 32'h11) $display("FAIL add_rd1: got %0h expected 11", bus.RD1E); else passed++;
    total++; if (bus.RD2E !== 32'h22) $display("FAIL add_rd2: got %0h expected 22", bus.RD2E); else passed++;
    total++; if (bus.RdE !== 5'd3) $display("FAIL add_rd: got %0d expected 3", bus.RdE); else passed++;
    total++; if (bus.ValidE !== 1'b1 || bus.RegWriteE !== 1'b1) $display("FAIL add_valid_regw: got %b%b expected 11", bus.ValidE, bus.RegWriteE); else passed++;
    total++; if (bus.PCE !== 32'h40 || bus.PCPlus4E !== 32'h44 || bus.ImmExtE !== 32'h7 || bus.Funct3E !== 3'b101)
      $display("FAIL add_fields: got pc=%0h pc4=%0h imm=%0h f3=%0h expected 40 44 7 5", bus.PCE, bus.PCPlus4E, bus.ImmExtE, bus.Funct3E); else passed++;
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) $display("FAIL add_stall_e: got %b%b expected 00", stall_f, stall_d); else passed++;
  endtask

  task automatic test_load_use();
    set_instr(OP_LOAD, 5'd1, 5'd0, 5'd5, RESULT_MEM, 1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    set_instr(OP_R, 5'd5, 5'd0, 5'd6, RESULT_ALU, 1'b1, 1'b0, 1'b0, 4'h0, 32'h55, 32'h0);
    total++; if (stall_f !== 1'b1 || stall_d !== 1'b1) $display("FAIL lu_stall: got %b%b expected 11", stall_f, stall_d); else passed++;
    step();
    exp_cnt++;
    total++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0 || bus.ResultSrcE !== 2'b00)
      $display("FAIL lu_bubble: got v=%b rw=%b rs=%0h expected 0 0 0", bus.ValidE, bus.RegWriteE, bus.ResultSrcE); else passed++;
    total++; if (bubble_cnt !== exp_cnt) $display("FAIL lu_cnt: got %0d expected %0d", bubble_cnt, exp_cnt); else passed++;
    total++; if (stall_f !== 1'b0) $display("FAIL lu_release: got %b expected 0", stall_f); else passed++;
    step();
    total++; if (bus.RdE !== 5'd6 || bus.ValidE !== 1'b1) $display("FAIL lu_issue: got rd=%0d v=%b expected 6 1", bus.RdE, bus.ValidE); else passed++;
    // Store reads the load result through rs2.
    set_instr(OP_LOAD, 5'd1, 5'd0, 5'd5, RESULT_MEM, 1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    set_instr(OP_S, 5'd1, 5'd5, 5'd0, RESULT_ALU, 1'b0, 1'b1, 1'b1, 4'h0, 32'h100, 32'h0);
    total++; if (stall_f !== 1'b1) $display("FAIL sw_stall: got %b expected 1", stall_f); else passed++;
    step();
    exp_cnt++;
    total++; if (bus.ValidE !== 1'b0 || bubble_cnt !== exp_cnt) $display("FAIL sw_bubble: got v=%b cnt=%0d expected 0 %0d", bus.ValidE, bubble_cnt, exp_cnt); else passed++;
    step();
    total++; if (bus.MemWriteE !== 1'b1 || bus.ValidE !== 1'b1) $display("FAIL sw_issue: got mw=%b v=%b expected 1 1", bus.MemWriteE, bus.ValidE); else passed++;
  endtask

  task automatic test_no_stall();
    set_instr(OP_LOAD, 5'd1, 5'd0, 5'd5, RESULT_MEM, 1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    set_instr(OP_LUI, 5'd5, 5'd5, 5'd5, RESULT_ALU, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) $display("FAIL lui_stall: got %b%b expected 00", stall_f, stall_d); else passed++;
    step();
    total++; if (bus.ValidE !== 1'b1 || bubble_cnt !== exp_cnt) $display("FAIL lui_issue: got v=%b cnt=%0d expected 1 %0d", bus.ValidE, bubble_cnt, exp_cnt); else passed++;
    set_instr(OP_LOAD, 5'd1, 5'd0, 5'd0, RESULT_MEM, 1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    set_instr(OP_R, 5'd0, 5'd0, 5'd6, RESULT_ALU, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    total++; if (stall_f !== 1'b0) $display("FAIL x0_stall: got %b expected 0", stall_f); else passed++;
    step();
    total++; if (bus.ValidE !== 1'b1 || bus.RdE !== 5'd6) $display("FAIL x0_issue: got v=%b rd=%0d expected 1 6", bus.ValidE, bus.RdE); else passed++;
  endtask

  task automatic test_flush();
    set_instr(OP_LOAD, 5'd1, 5'd0, 5'd5, RESULT_MEM, 1'b1, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
    step();
    flush_e = 1'b1;
    set_instr(OP_R, 5'd5, 5'd1, 5'd7, RESULT_ALU, 1'b1, 1'b0, 1'b0, 4'h1, 32'h0, 32'h0);
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) $display("FAIL flush_stall: got %b%b expected 00", stall_f, stall_d); else passed++;
    step();
    flush_e = 1'b0;
    exp_cnt++;
    total++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0) $display("FAIL flush_bubble: got v=%b rw=%b expected 0 0", bus.ValidE, bus.RegWriteE); else passed++;
    total++; if (bubble_cnt !== exp_cnt) $display("FAIL flush_cnt: got %0d expected %0d", bubble_cnt, exp_cnt); else passed++;
    step();
    total++; if (bus.RdE !== 5'd7 || bus.ALUControlE !== 4'h1 || bus.ValidE !== 1'b1)
      $display("FAIL flush_next: got rd=%0d alu=%0h v=%b expected 7 1 1", bus.RdE, bus.ALUControlE, bus.ValidE); else passed++;
  endtask

  task automatic test_saturate();
    flush4 = 1'b1;
    repeat (14) step();
    total++; if (cnt4 !== 4'd14) $display("FAIL sat_14: got %0d expected 14", cnt4); else passed++;
    step();
    total++; if (cnt4 !== 4'd15) $display("FAIL sat_15: got %0d expected 15", cnt4); else passed++;
    repeat (3) step();
    total++; if (cnt4 !== 4'd15 || bus4.ValidE !== 1'b0) $display("FAIL sat_hold: got cnt=%0d v=%b expected 15 0", cnt4, bus4.ValidE); else passed++;
    flush4 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    bus.PCD = 32'h80; bus.ImmExtD = 32'hABC;
    set_instr(OP_R, 5'd9, 5'd10, 5'd11, RESULT_PC4, 1'b1, 1'b1, 1'b1, 4'h5, 32'hDEAD, 32'hBEEF);
    step();
    total++; if (bus.RdE !== 5'd11 || bubble_cnt !== exp_cnt) $display("FAIL pre_reset: got rd=%0d cnt=%0d expected 11 %0d", bus.RdE, bubble_cnt, exp_cnt); else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0 || bus.ResultSrcE !== 2'b00 || bus.ALUControlE !== 4'h0)
      $display("FAIL arst_ctrl: got v=%b rw=%b rs=%0h alu=%0h expected 0 0 0 0", bus.ValidE, bus.RegWriteE, bus.ResultSrcE, bus.ALUControlE); else passed++;
    total++; if (bus.RD1E !== 32'h0 || bus.RdE !== 5'd0 || bus.PCE !== 32'h0 || bus.ImmExtE !== 32'h0)
      $display("FAIL arst_data: got rd1=%0h rd=%0d pc=%0h imm=%0h expected 0 0 0 0", bus.RD1E, bus.RdE, bus.PCE, bus.ImmExtE); else passed++;
    total++; if (bubble_cnt !== 32'd0 || cnt4 !== 4'd0) $display("FAIL arst_cnt: got %0d %0d expected 0 0", bubble_cnt, cnt4); else passed++;
    total++; if (stall_f !== 1'b0 || stall_d !== 1'b0) $display("FAIL arst_stall: got %b%b expected 00", stall_f, stall_d); else passed++;
    step();
    rst = 1'b0;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    exp_cnt = 0;
    test_reset();
    test_add();
    test_load_use();
    test_no_stall();
    test_flush();
    test_saturate();
    test_reset_midrun();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
